// File: rtl/keypad_encoder.sv
// 4x3 active-low keypad scanner/debouncer: one Code_1/Valid_1 strobe per debounced press.
// Latency: Valid_1 lands DEBOUNCE_CNT cycles after the detecting scan sample; no backpressure (strobe only).
module keypad_encoder #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       reset_1,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [3:0] Code_1,
    output logic       Valid_1,
    output logic       key_down
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] PRESS_LAST = CW'(DEBOUNCE_CNT - 2);
    localparam logic [CW-1:0] REL_LAST   = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESS    = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    logic [2:0]    col_s1;
    logic [2:0]    col_s2;
    logic [2:0]    colp;
    logic          colp_valid;
    state_t        state;
    state_t        state_nxt;
    logic [1:0]    row_idx;
    logic [1:0]    row_idx_nxt;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    pat;
    logic [2:0]    pat_nxt;
    logic [3:0]    row_dec;
    logic [3:0]    code_dec;

    // Columns are asynchronous to clk; reset to all-ones so nothing looks pressed.
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            col_s1 <= 3'b111;
            col_s2 <= 3'b111;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    assign colp       = ~col_s2;
    assign colp_valid = (colp == 3'b001) || (colp == 3'b010) || (colp == 3'b100);

    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            state   <= S_SCAN;
            row_idx <= 2'd0;
            dwell   <= '0;
            cnt     <= '0;
            pat     <= 3'b000;
        end else begin
            state   <= state_nxt;
            row_idx <= row_idx_nxt;
            dwell   <= dwell_nxt;
            cnt     <= cnt_nxt;
            pat     <= pat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        dwell_nxt   = dwell;
        cnt_nxt     = cnt;
        pat_nxt     = pat;
        case (state)
            S_SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (colp_valid) begin
                        state_nxt = S_DEBOUNCE;
                        pat_nxt   = colp;
                        cnt_nxt   = '0;
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end else begin
                    dwell_nxt = dwell + DW'(1);
                end
            end
            S_DEBOUNCE: begin
                if (colp != pat) begin
                    // Glitch: drop it and carry on scanning from the following row.
                    state_nxt   = S_SCAN;
                    row_idx_nxt = row_idx + 2'd1;
                    dwell_nxt   = '0;
                    cnt_nxt     = '0;
                end else if (cnt == PRESS_LAST) begin
                    state_nxt = S_PRESS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_PRESS: begin
                state_nxt = S_HOLD;
                cnt_nxt   = '0;
            end
            S_HOLD: begin
                if (colp != 3'b000) begin
                    cnt_nxt = '0;
                end else if (cnt == REL_LAST) begin
                    state_nxt   = S_SCAN;
                    row_idx_nxt = 2'd0;
                    dwell_nxt   = '0;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_SCAN;
            end
        endcase
    end

    // Layout: r0 = 1,2,3 / r1 = 4,5,6 / r2 = 7,8,9 / r3 = *,0,#.
    always_comb begin
        row_dec  = ~(4'b0001 << row_idx_nxt);
        code_dec = 4'b0000;
        case ({row_idx, pat})
            {2'd0, 3'b001}: code_dec = 4'd1;
            {2'd0, 3'b010}: code_dec = 4'd2;
            {2'd0, 3'b100}: code_dec = 4'd3;
            {2'd1, 3'b001}: code_dec = 4'd4;
            {2'd1, 3'b010}: code_dec = 4'd5;
            {2'd1, 3'b100}: code_dec = 4'd6;
            {2'd2, 3'b001}: code_dec = 4'd7;
            {2'd2, 3'b010}: code_dec = 4'd8;
            {2'd2, 3'b100}: code_dec = 4'd9;
            {2'd3, 3'b001}: code_dec = 4'd10;
            {2'd3, 3'b010}: code_dec = 4'd0;
            {2'd3, 3'b100}: code_dec = 4'd11;
            default:        code_dec = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            row      <= 4'b1110;
            Code_1   <= 4'b0000;
            Valid_1  <= 1'b0;
            key_down <= 1'b0;
        end else begin
            row      <= row_dec;
            Valid_1  <= (state_nxt == S_PRESS);
            key_down <= (state_nxt == S_PRESS) || (state_nxt == S_HOLD);
            if (state_nxt == S_PRESS) begin
                Code_1 <= code_dec;
            end
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Randomized keypad bench: per-cycle comparison against a timestamp-based model of the keypad encoder.
module tb_keypad_encoder;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int M_SCAN  = 0;
    localparam int M_DEB   = 1;
    localparam int M_PRESS = 2;
    localparam int M_HOLD  = 3;

    logic        clk;
    logic        reset_1;
    logic [2:0]  col;
    logic [3:0]  row;
    logic [3:0]  Code_1;
    logic        Valid_1;
    logic        key_down;
    logic [11:0] keys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    // Model state: mode plus timestamps/positions describing the current cycle.
    int m_mode = M_SCAN;
    int m_pos = 0;
    int m_crow = 0;
    int m_rel = -1;
    int m_capt_cyc = 0;
    logic [2:0] m_pat = 3'b000;
    logic [3:0] m_code = 4'b0000;
    logic [2:0] c_last = 3'b111;
    logic [2:0] c_prev = 3'b111;

    // Monitor results.
    int v_count = 0;
    int v_cyc = 0;
    int kd_fall_cyc = 0;
    logic [3:0] last_code = 4'b0000;
    logic prev_valid = 1'b0;
    logic prev_kd = 1'b0;

    keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk      (clk),
        .reset_1  (reset_1),
        .col      (col),
        .row      (row),
        .Code_1   (Code_1),
        .Valid_1  (Valid_1),
        .key_down (key_down)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Physical keypad: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !row[r]) col[c] = 1'b0;
    end

    function automatic logic [3:0] key_code(input int r, input logic [2:0] p);
        string layout;
        byte   ch;
        int    c;
        layout = "123456789*0#";
        c = 0;
        for (int i = 0; i < 3; i++) if (p[i]) c = i;
        ch = layout[r*3+c];
        if (ch == "*") return 4'd10;
        if (ch == "#") return 4'd11;
        return 4'(ch - "0");
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_1) begin
        logic [2:0] colp;
        if (!reset_1) begin
            m_mode = M_SCAN;
            m_pos  = 0;
            m_rel  = -1;
            m_code = 4'b0000;
            c_last = 3'b111;
            c_prev = 3'b111;
        end else begin
            colp = ~c_prev;
            case (m_mode)
                M_SCAN: begin
                    if ((m_pos % SD) == SD - 1 && $countones(colp) == 1) begin
                        m_mode     = M_DEB;
                        m_crow     = m_pos / SD;
                        m_pat      = colp;
                        m_capt_cyc = cyc;
                    end else begin
                        m_pos = (m_pos + 1) % (4 * SD);
                    end
                end
                M_DEB: begin
                    if (colp != m_pat) begin
                        m_mode = M_SCAN;
                        m_pos  = ((m_crow + 1) % 4) * SD;
                    end else if (cyc - m_capt_cyc == DB - 1) begin
                        m_mode = M_PRESS;
                        m_code = key_code(m_crow, m_pat);
                    end
                end
                M_PRESS: begin
                    m_mode = M_HOLD;
                    m_rel  = -1;
                end
                default: begin
                    if (colp != 3'b000) begin
                        m_rel = -1;
                    end else begin
                        if (m_rel < 0) m_rel = cyc;
                        if (cyc - m_rel == DB - 1) begin
                            m_mode = M_SCAN;
                            m_pos  = 0;
                        end
                    end
                end
            endcase
            c_prev = c_last;
            c_last = col;
        end
    end

    always @(negedge clk) begin
        int r;
        logic [3:0] exp_row;
        if (chk_en) begin
            r = (m_mode == M_SCAN) ? m_pos / SD : m_crow;
            exp_row = 4'b1111 ^ (4'b0001 << r);
            check("row", row, exp_row);
            check("valid", Valid_1, m_mode == M_PRESS);
            check("key_down", key_down, m_mode == M_PRESS || m_mode == M_HOLD);
            check("code", Code_1, m_code);
            check("row_onehot", $countones(~row), 1);
            check("valid_back_to_back", prev_valid & Valid_1, 0);
            if (Valid_1) begin
                v_count   = v_count + 1;
                v_cyc     = cyc;
                last_code = Code_1;
            end
            if (prev_kd && !key_down) kd_fall_cyc = cyc;
            prev_valid = Valid_1;
            prev_kd    = key_down;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input int n);
        reset_1 = 1'b0;
        cycles(n);
        reset_1 = 1'b1;
    endtask

    task automatic wait_valid(input int target, input int budget, input string name);
        int n = 0;
        while (v_count < target && n < budget) begin
            cycles(1);
            n++;
        end
        check(name, v_count, target);
    endtask

    task automatic wait_kd(input logic lvl, input int budget, input string name);
        int n = 0;
        while (key_down !== lvl && n < budget) begin
            cycles(1);
            n++;
        end
        check(name, key_down, lvl);
    endtask

    initial begin
        logic [3:0] rot [4];
        int base, pc, rel_cyc, n, k, k2, nb;
        rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;
        reset_1 = 1'b0;
        keys = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        cycles(1);

        // Reset with random keys held.
        keys = 12'($urandom);
        cycles(3);
        check("rst_row", row, 4'b1110);
        check("rst_code", Code_1, 4'b0000);
        check("rst_valid", Valid_1, 1'b0);
        check("rst_key_down", key_down, 1'b0);
        keys = '0;
        cycles(2);
        reset_1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("rotation", row, rot[i/4]);
            cycles(1);
        end

        // Clean press of '5'.
        base = v_count;
        pc = cyc;
        keys[4] = 1'b1;
        wait_valid(base + 1, 40, "p5_detect");
        check("p5_latency", v_cyc - m_capt_cyc, DB);
        check("p5_code", last_code, 4'b0101);
        n = 40 - (cyc - pc);
        if (n > 0) cycles(n);
        keys = '0;
        rel_cyc = cyc;
        wait_kd(1'b0, 30, "p5_release");
        check("p5_release_lat", kd_fall_cyc - rel_cyc, DB + 2);
        check("p5_count", v_count - base, 1);
        cycles(10);

        // Bouncing '#'.
        base = v_count;
        for (int i = 0; i < 7; i++) begin
            keys[11] = ~keys[11];
            cycles(3);
        end
        check("bounce_quiet", v_count - base, 0);
        wait_valid(base + 1, 40, "bounce_detect");
        check("bounce_code", last_code, 4'b1011);
        cycles(10);
        keys = '0;
        wait_kd(1'b0, 30, "bounce_release");
        check("bounce_count", v_count - base, 1);
        cycles(10);

        // '1' and '3' together, then '1' alone.
        base = v_count;
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        cycles(40);
        check("multi_quiet", v_count - base, 0);
        keys[2] = 1'b0;
        wait_valid(base + 1, 40, "multi_detect");
        check("multi_code", last_code, 4'b0001);
        keys = '0;
        wait_kd(1'b0, 30, "multi_release");
        cycles(10);

        // '*' held, '0' added during hold, then '0' alone.
        base = v_count;
        keys[9] = 1'b1;
        wait_kd(1'b1, 40, "star_down");
        cycles(3);
        keys[10] = 1'b1;
        cycles(20);
        keys = '0;
        wait_kd(1'b0, 30, "star_release");
        check("star_count", v_count - base, 1);
        check("star_code", last_code, 4'b1010);
        cycles(10);
        keys[10] = 1'b1;
        wait_valid(base + 2, 40, "zero_detect");
        check("zero_code", last_code, 4'b0000);
        keys = '0;
        wait_kd(1'b0, 30, "zero_release");
        cycles(10);

        // Reset in the middle of debouncing '9'.
        base = v_count;
        keys[8] = 1'b1;
        n = 0;
        while (!(m_mode == M_DEB && cyc - m_capt_cyc == 6) && n < 40) begin
            cycles(1);
            n++;
        end
        check("nine_deb_cnt5", (m_mode == M_DEB && cyc - m_capt_cyc == 6), 1);
        pulse_reset(3);
        check("nine_no_valid", v_count - base, 0);
        wait_valid(base + 1, 40, "nine_detect");
        check("nine_code", last_code, 4'b1001);
        keys = '0;
        wait_kd(1'b0, 30, "nine_release");
        cycles(10);

        // Random presses with bounce, overlaps and occasional resets.
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 11);
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                keys[k] = ~keys[k];
                cycles($urandom_range(1, 5));
            end
            keys[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                k2 = $urandom_range(0, 11);
                cycles($urandom_range(0, 20));
                keys[k2] = 1'b1;
            end
            cycles($urandom_range(5, 50));
            if ($urandom_range(0, 7) == 0) pulse_reset($urandom_range(1, 3));
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                keys[k] = ~keys[k];
                cycles($urandom_range(1, 5));
            end
            keys = '0;
            cycles($urandom_range(1, 30));
        end

        // Press '8', then reset must clear the held code.
        cycles(30);
        base = v_count;
        keys[7] = 1'b1;
        wait_valid(base + 1, 40, "eight_detect");
        check("eight_code", last_code, 4'b1000);
        reset_1 = 1'b0;
        cycles(1);
        check("rst2_code", Code_1, 4'b0000);
        check("rst2_key_down", key_down, 1'b0);
        check("rst2_row", row, 4'b1110);
        keys = '0;
        reset_1 = 1'b1;
        cycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
